hs_sink_fifo: RTL



---
 rtl/hs_sink_fifo_if.sv | 12 +
 rtl/hs_sink_fifo.sv | 96 +++++++++
 2 files changed

// File: rtl/hs_sink_fifo_if.sv
// Valid/ready payload channel terminated by hs_sink_fifo.
// The master drives valid and data; the slave returns ready.
interface hs_sink_fifo_if #(
   parameter int WIDTH = 8
);
   logic             s_valid;
   logic [WIDTH-1:0] s_data_in;
   logic             s_ready;

   modport master (output s_valid, output s_data_in, input s_ready);
   modport slave  (input s_valid, input s_data_in, output s_ready);
endinterface

// File: rtl/hs_sink_fifo.sv
// Receiving end of a valid/ready channel: buffers beats in a small FIFO, drains
// them under en, counts accepted beats and flags breaks in the +1 payload sequence.
//
// state      | meaning
// ST_UNARMED | no beat since reset; the next accept only seeds the expected value
// ST_ARMED   | every accept is compared against the expected value
module hs_sink_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   hs_sink_fifo_if.slave          s,
   output logic [WIDTH-1:0]       s_data_out,
   output logic                   out_valid,
   output logic [$clog2(DEPTH):0] fifo_cnt,
   output logic [CNT_W-1:0]       beat_cnt,
   output logic                   seq_err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] ST_UNARMED = 1'b0;
   localparam logic [0:0] ST_ARMED   = 1'b1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [0:0]       seq_state;
   logic [WIDTH-1:0] seq_exp;
   logic             full;
   logic             push;
   logic             pop;

   // Ready depends only on registered occupancy and rst, never on s_valid.
   assign full      = (fifo_cnt == (AW+1)'(DEPTH));
   assign s.s_ready = !rst && !full;
   assign push      = s.s_valid && s.s_ready;
   assign pop       = en && (fifo_cnt != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s.s_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         s_data_out <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= pop;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            s_data_out <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (push && (beat_cnt != '1)) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   // Expected value always resyncs to the received beat, so one glitch logs once.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_state <= ST_UNARMED;
         seq_exp   <= '0;
         seq_err   <= 1'b0;
      end else if (push) begin
         seq_exp <= s.s_data_in + WIDTH'(1);
         if (seq_state == ST_ARMED) begin
            if (s.s_data_in != seq_exp) begin
               seq_err <= 1'b1;
            end
         end else begin
            seq_state <= ST_ARMED;
         end
      end
   end
endmodule
